piso_encoder: RTL and testbench

- Upstream neighbour of the serial-in/parallel-out decoder: takes bytes from a producer over a valid/ready handshake and emits them as a continuous serial bit stream, LSB first.
- Its serialOut drives the decoder's serialIn directly on the same clock.
- A one-entry holding register lets bytes stream back to back with no idle bit between frames.

---
 rtl/piso_encoder.sv | 123 ++++++++++++
 tb/tb_piso_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/piso_encoder.sv
// ============================================================================
// piso_encoder : byte-to-serial encoder, LSB first, one-entry holding register
// Optional even-parity trailer bit enabled by defining EMDS_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataValid,
  output logic                  dataReady,
  output logic                  serialOut,
  output logic                  frameStart,
  output logic                  busy
);

`ifdef EMDS_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [FRAME_LEN-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  holdFull_q, holdFull_d;
  logic                  serial_q, serial_d;
  logic                  frameStart_q, frameStart_d;
  logic                  busy_q, busy_d;
  logic                  readyEn_q;

  logic [FRAME_LEN-1:0]  frame;
  logic                  accept;

`ifdef EMDS_PARITY_EN
  assign frame = {^hold_q, hold_q};
`else
  assign frame = hold_q;
`endif

  // readyEn_q keeps dataReady low throughout reset and until the first edge after it
  assign dataReady  = readyEn_q & ~holdFull_q;
  assign accept     = dataValid & dataReady;
  assign serialOut  = serial_q;
  assign frameStart = frameStart_q;
  assign busy       = busy_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      holdFull_q   <= 1'b0;
      serial_q     <= IDLE_LEVEL;
      frameStart_q <= 1'b0;
      busy_q       <= 1'b0;
      readyEn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      holdFull_q   <= holdFull_d;
      serial_q     <= serial_d;
      frameStart_q <= frameStart_d;
      busy_q       <= busy_d;
      readyEn_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    holdFull_d   = holdFull_q;
    serial_d     = serial_q;
    frameStart_d = 1'b0;
    busy_d       = busy_q;

    // A frame loads when idle, or on the last-bit edge so frames abut with no gap
    if ((state_q == IDLE || bitCnt_q == LAST_CNT) && holdFull_q) begin
      state_d      = SHIFT;
      shift_d      = frame >> 1;
      serial_d     = frame[0];
      frameStart_d = 1'b1;
      busy_d       = 1'b1;
      bitCnt_d     = '0;
      holdFull_d   = 1'b0;
    end else if (state_q == SHIFT && bitCnt_q != LAST_CNT) begin
      serial_d = shift_q[0];
      shift_d  = shift_q >> 1;
      bitCnt_d = bitCnt_q + 1'b1;
    end else if (state_q == SHIFT) begin
      state_d  = IDLE;
      serial_d = IDLE_LEVEL;
      busy_d   = 1'b0;
      bitCnt_d = '0;
    end

    if (accept) begin
      hold_d     = dataIn;
      holdFull_d = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_encoder.sv
// ============================================================================
// tb_piso_encoder : directed, table-driven bench for piso_encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_piso_encoder;

  logic       clock;
  logic       resetN;
  logic [7:0] dataIn;
  logic       dataValid;
  logic       dataReady;
  logic       serialOut;
  logic       frameStart;
  logic       busy;

  int errors = 0;
  int checks = 0;

  piso_encoder #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .dataIn     (dataIn),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .serialOut  (serialOut),
    .frameStart (frameStart),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] exp;  // {serialOut, frameStart, busy, dataReady} after the edge
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] exp01;
    logic [8:0] expPar;

    // Single A5, idle, then 3C/C3 back to back with backpressure on changing data
    vecs[0]  = '{1'b1, 8'hA5, 4'b0000};
    vecs[1]  = '{1'b0, 8'h00, 4'b1111};
    vecs[2]  = '{1'b0, 8'h00, 4'b0011};
    vecs[3]  = '{1'b0, 8'h00, 4'b1011};
    vecs[4]  = '{1'b0, 8'h00, 4'b0011};
    vecs[5]  = '{1'b0, 8'h00, 4'b0011};
    vecs[6]  = '{1'b0, 8'h00, 4'b1011};
    vecs[7]  = '{1'b0, 8'h00, 4'b0011};
    vecs[8]  = '{1'b0, 8'h00, 4'b1011};
    vecs[9]  = '{1'b0, 8'h00, 4'b0001};
    vecs[10] = '{1'b1, 8'h3C, 4'b0000};
    vecs[11] = '{1'b1, 8'hC3, 4'b0111};
    vecs[12] = '{1'b1, 8'hC3, 4'b0010};
    vecs[13] = '{1'b1, 8'h55, 4'b1010};
    vecs[14] = '{1'b1, 8'h66, 4'b1010};
    vecs[15] = '{1'b1, 8'h77, 4'b1010};
    vecs[16] = '{1'b0, 8'h00, 4'b1010};
    vecs[17] = '{1'b0, 8'h00, 4'b0010};
    vecs[18] = '{1'b0, 8'h00, 4'b0010};
    vecs[19] = '{1'b0, 8'h00, 4'b1111};
    vecs[20] = '{1'b0, 8'h00, 4'b1011};
    vecs[21] = '{1'b0, 8'h00, 4'b0011};
    vecs[22] = '{1'b0, 8'h00, 4'b0011};
    vecs[23] = '{1'b0, 8'h00, 4'b0011};
    vecs[24] = '{1'b0, 8'h00, 4'b0011};
    vecs[25] = '{1'b0, 8'h00, 4'b1011};
    vecs[26] = '{1'b0, 8'h00, 4'b1011};
    vecs[27] = '{1'b0, 8'h00, 4'b0001};

    resetN    = 1'b0;
    dataValid = 1'b0;
    dataIn    = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {28'd0, serialOut, frameStart, busy, dataReady}, 32'h0);
    resetN = 1'b1;
    #1;
    chk("ready_low_before_edge", {31'd0, dataReady}, 32'd0);
    @(negedge clock);
    chk("idle_after_release", {28'd0, serialOut, frameStart, busy, dataReady}, 32'h1);

`ifdef EMDS_PARITY_EN
    expPar    = 9'b1_0000_0111;
    dataValid = 1'b1;
    dataIn    = 8'h07;
    tick();
    dataIn = 8'h09;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("par_bit%0d", i), {31'd0, serialOut}, {31'd0, expPar[i]});
      chk($sformatf("par_fs%0d", i), {31'd0, frameStart}, (i == 0) ? 32'd1 : 32'd0);
    end
    tick();
    chk("par_next_frame_fs", {31'd0, frameStart}, 32'd1);
    chk("par_next_frame_bit0", {31'd0, serialOut}, 32'd1);
    dataValid = 1'b0;
    repeat (25) tick();
`else
    for (int i = 0; i < 28; i++) begin
      dataValid = vecs[i].v;
      dataIn    = vecs[i].d;
      tick();
      chk($sformatf("vec%0d", i), {28'd0, serialOut, frameStart, busy, dataReady},
          {28'd0, vecs[i].exp});
    end
    dataValid = 1'b0;
`endif

    // Reset in the middle of an all-ones frame
    dataValid = 1'b1;
    dataIn    = 8'hFF;
    tick();
    dataValid = 1'b0;
    repeat (4) tick();
    chk("ff_mid_frame_busy", {30'd0, serialOut, busy}, 32'h3);
    resetN = 1'b0;
    #1;
    chk("abort_async", {28'd0, serialOut, frameStart, busy, dataReady}, 32'h0);
    repeat (2) tick();
    resetN = 1'b1;
    @(negedge clock);
    chk("abort_release_idle", {28'd0, serialOut, frameStart, busy, dataReady}, 32'h1);

    exp01     = 8'h01;
    dataValid = 1'b1;
    dataIn    = 8'h01;
    tick();
    dataValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("b01_bit%0d", i), {30'd0, serialOut, busy}, {30'd0, exp01[i], 1'b1});
      chk($sformatf("b01_fs%0d", i), {31'd0, frameStart}, (i == 0) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
